mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Memory-stage access controller between the EX/MEM pipeline register and the word-addressed data memory.
//  Converts one EX/MEM load/store request into a correctly timed memory transaction:
//   - loads: a held, gated read with programmable wait states
//   - stores: setup/strobe/hold around the memory's rising-edge write latch
//  Stalls the pipeline while busy, then delivers a one-cycle result beat to the MEM/WB register.
// PARAMETERS
//  MEM_DEPTH    128  words in data memory; AW = $clog2(MEM_DEPTH) = 7
//  WAIT_CYCLES  2    extra read wait states, legal range 0..15 (4-bit counter)
// PORTS
//  clk                       in   1   single clock; all state updates on posedge
//  rst                       in   1   synchronous, active-high reset
//  ex_mem_valid              in   1   EX/MEM holds a valid instruction this cycle
//  ex_mem_memory_read        in   1   instruction is a load
//  ex_mem_memory_write       in   1   instruction is a store
//  ex_mem_memory_address     in   32  byte address from EX
//  ex_mem_memory_write_data  in   32  store data
//  mem_stall                 out  1   hold EX/MEM and all earlier stages (combinational)
//  dm_memory_read            out  1   data-memory read enable
//  dm_memory_write           out  1   data-memory write strobe; memory latches on its rising edge
//  dm_memory_address         out  AW  word address = ex_mem_memory_address[AW+1:2]
//  dm_memory_write_data      out  32  store data to memory
//  dm_read_data              in   32  combinational read data from memory
//  mem_wb_valid              out  1   one-cycle result beat to MEM/WB
//  mem_wb_read_data          out  32  load result; 0 for non-loads and errors
//  mem_wb_addr_error         out  1   beat carries a rejected access
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - state=IDLE, wait counter=0
//   - all registered outputs 0: dm_*, mem_wb_*
//   - mem_stall=0 while in IDLE with no request
//  Request classification in IDLE, when ex_mem_valid=1:
//   - Legal load: read=1, write=0, addr[1:0]=0, addr[31:2] < MEM_DEPTH.
//   - Legal store: write=1, read=0, same address checks.
//   - Error: read=1 and write=1, or misaligned, or out of range.
//     No dm strobes; mem_wb_valid=1, addr_error=1, read_data=0 next cycle; mem_stall=0.
//   - Non-memory (read=0, write=0): mem_wb_valid=1, read_data=0, error=0 next cycle; no stall.
//  FSM states: IDLE, RD_WAIT, WR_SETUP, WR_STROBE, WR_HOLD.
//   - IDLE, legal load: mem_stall=1. Latch address and data, counter<=WAIT_CYCLES, go to RD_WAIT.
//   - RD_WAIT: dm_memory_read=1 and address held.
//     - counter != 0: counter decrements, mem_stall=1.
//     - counter == 0: mem_stall=0; capture dm_read_data into mem_wb_read_data, mem_wb_valid<=1, go to IDLE.
//   - IDLE, legal store: mem_stall=1, latch address and data, go to WR_SETUP.
//   - WR_SETUP: address/data driven, write=0, stall=1; go to WR_STROBE.
//   - WR_STROBE: dm_memory_write=1, stall=1; go to WR_HOLD.
//   - WR_HOLD: write=0, address/data held, stall=0. mem_wb_valid<=1 with read_data=0; go to IDLE.
//  Latency from request seen in IDLE at cycle 0:
//   - load: stall in cycles 0..W; beat in cycle W+2
//   - store: stall in cycles 0..2; write pulse in cycle 2 only; beat in cycle 4
//  Stall dropping in the final busy cycle lets EX/MEM advance at that edge. A new request is taken in the next IDLE cycle, so a request is never accepted twice.
//  dm_memory_read and dm_memory_write are never high together. Both are 0 and address is 0 in IDLE.
//  mem_wb_valid is a single-cycle pulse; the other mem_wb_* outputs hold until the next beat.
//  Reset mid-operation aborts immediately: state goes to IDLE and strobes drop at that edge.
//   - Reset before WR_STROBE: no write reaches memory.
//   - Reset during WR_STROBE: the write has already occurred.
// TESTING
//  T1 reset: rst=1 for 2 cycles mid-load -> all outputs 0, mem_stall=0, state IDLE.
//  T2 load W=2, addr 0x10, word4=0x0000000C
//     -> mem_stall high cycles 0-2; dm_memory_read high cycles 1-3 with address 4.
//     -> mem_wb_valid=1 and read_data=0x0000000C in cycle 4.
//  T3 store 0xDEADBEEF to 0x20
//     -> dm_memory_write high in cycle 2 only; address 8 and data stable in cycles 1-3.
//     -> follow-on load of 0x20 returns 0xDEADBEEF.
//  T4 load 0x13 (misaligned), then load 0x200 (out of range), then read+write set together
//     -> no dm strobes, mem_stall=0 each time; one beat each with addr_error=1, read_data=0.
//  T5 back-to-back: store 0x20, load 0x20, then non-memory instruction
//     -> no cycle lost between completions; load returns stored data.
//     -> non-memory beat arrives 1 cycle after it is presented.
//  T6 rst asserted during WR_SETUP
//     -> dm_memory_write never rises; memory word unchanged; next request served normally.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: turns one EX/MEM load/store into a timed data-memory transaction.
// Latency: load beat W+2 cycles after the request, store beat 4, error/non-memory beat 1.
// Backpressure: mem_stall (combinational) holds EX/MEM until the final busy cycle.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   ex_mem_*                  request from the EX/MEM register (valid, read, write, byte address, store data)
//   mem_stall                 hold EX/MEM and earlier stages while a legal access is in flight
//   dm_memory_*               data-memory read enable, write strobe (latched on its rising edge), word address, data
//   dm_read_data              combinational read data from memory
//   mem_wb_*                  one-cycle result beat: valid pulse, load data, address-error flag
module mem_access_ctrl #(
  parameter int MEM_DEPTH   = 128,
  parameter int WAIT_CYCLES = 2,
  localparam int AW         = $clog2(MEM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_mem_valid,
  input  logic          ex_mem_memory_read,
  input  logic          ex_mem_memory_write,
  input  logic [31:0]   ex_mem_memory_address,
  input  logic [31:0]   ex_mem_memory_write_data,
  output logic          mem_stall,
  output logic          dm_memory_read,
  output logic          dm_memory_write,
  output logic [AW-1:0] dm_memory_address,
  output logic [31:0]   dm_memory_write_data,
  input  logic [31:0]   dm_read_data,
  output logic          mem_wb_valid,
  output logic [31:0]   mem_wb_read_data,
  output logic          mem_wb_addr_error
);

  localparam logic [31:0] DEPTH32    = 32'(MEM_DEPTH);
  localparam logic [3:0]  WAIT_INIT  = 4'(WAIT_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    WR_SETUP,
    WR_STROBE,
    WR_HOLD
  } state_e;

  state_e        state_q;
  logic [3:0]    wait_cnt_q;
  logic          dm_memory_read_q;
  logic          dm_memory_write_q;
  logic [AW-1:0] dm_memory_address_q;
  logic [31:0]   dm_memory_write_data_q;
  logic          mem_wb_valid_q;
  logic [31:0]   mem_wb_read_data_q;
  logic          mem_wb_addr_error_q;

  // Request classification, only acted on in IDLE.
  logic          aligned;
  logic          in_range;
  logic          legal_load;
  logic          legal_store;
  logic          is_error;
  logic [AW-1:0] word_addr_d;

  assign aligned     = (ex_mem_memory_address[1:0] == 2'b00);
  assign in_range    = ({2'b00, ex_mem_memory_address[31:2]} < DEPTH32);
  assign legal_load  = ex_mem_memory_read & ~ex_mem_memory_write & aligned & in_range;
  assign legal_store = ex_mem_memory_write & ~ex_mem_memory_read & aligned & in_range;
  // Any memory op that is not a legal load/store is rejected; read=write=0 is a plain non-memory op.
  assign is_error    = (ex_mem_memory_read | ex_mem_memory_write) & ~(legal_load | legal_store);
  assign word_addr_d = ex_mem_memory_address[AW+1:2];

  // Stall drops in the last busy cycle so EX/MEM advances on the same edge the beat is issued.
  always_comb begin
    mem_stall = 1'b0;
    case (state_q)
      IDLE:                mem_stall = ex_mem_valid & (legal_load | legal_store);
      RD_WAIT:             mem_stall = (wait_cnt_q != 4'd0);
      WR_SETUP, WR_STROBE: mem_stall = 1'b1;
      default:             mem_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q                <= IDLE;
      wait_cnt_q             <= 4'd0;
      dm_memory_read_q       <= 1'b0;
      dm_memory_write_q      <= 1'b0;
      dm_memory_address_q    <= '0;
      dm_memory_write_data_q <= 32'd0;
      mem_wb_valid_q         <= 1'b0;
      mem_wb_read_data_q     <= 32'd0;
      mem_wb_addr_error_q    <= 1'b0;
    end else begin
      // The beat is a single-cycle pulse; data and error hold until the next beat.
      mem_wb_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ex_mem_valid) begin
            if (legal_load) begin
              state_q                <= RD_WAIT;
              wait_cnt_q             <= WAIT_INIT;
              dm_memory_read_q       <= 1'b1;
              dm_memory_address_q    <= word_addr_d;
              dm_memory_write_data_q <= ex_mem_memory_write_data;
            end else if (legal_store) begin
              state_q                <= WR_SETUP;
              dm_memory_address_q    <= word_addr_d;
              dm_memory_write_data_q <= ex_mem_memory_write_data;
            end else begin
              // Rejected or non-memory: no strobes, immediate beat.
              mem_wb_valid_q      <= 1'b1;
              mem_wb_read_data_q  <= 32'd0;
              mem_wb_addr_error_q <= is_error;
            end
          end
        end

        RD_WAIT: begin
          if (wait_cnt_q != 4'd0) begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
          end else begin
            state_q                <= IDLE;
            dm_memory_read_q       <= 1'b0;
            dm_memory_address_q    <= '0;
            dm_memory_write_data_q <= 32'd0;
            mem_wb_valid_q         <= 1'b1;
            mem_wb_read_data_q     <= dm_read_data;
            mem_wb_addr_error_q    <= 1'b0;
          end
        end

        // Address/data are already stable one cycle before the write strobe rises.
        WR_SETUP: begin
          state_q           <= WR_STROBE;
          dm_memory_write_q <= 1'b1;
        end

        WR_STROBE: begin
          state_q           <= WR_HOLD;
          dm_memory_write_q <= 1'b0;
        end

        // Address/data held one cycle past the strobe, then released.
        WR_HOLD: begin
          state_q                <= IDLE;
          dm_memory_address_q    <= '0;
          dm_memory_write_data_q <= 32'd0;
          mem_wb_valid_q         <= 1'b1;
          mem_wb_read_data_q     <= 32'd0;
          mem_wb_addr_error_q    <= 1'b0;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign dm_memory_read       = dm_memory_read_q;
  assign dm_memory_write      = dm_memory_write_q;
  assign dm_memory_address    = dm_memory_address_q;
  assign dm_memory_write_data = dm_memory_write_data_q;
  assign mem_wb_valid         = mem_wb_valid_q;
  assign mem_wb_read_data     = mem_wb_read_data_q;
  assign mem_wb_addr_error    = mem_wb_addr_error_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed and randomized requests against a transaction-level reference.
// Latency: expected beat cycle computed per request from its class (load W+2, store 4, other 1).
// Backpressure: driver holds each request while mem_stall is high, bounded by a cycle budget.
module tb_mem_access_ctrl;

  localparam int MEM_DEPTH = 128;
  localparam int W         = 2;
  localparam int AW        = $clog2(MEM_DEPTH);

  logic          clk = 1'b0;
  logic          rst;
  logic          ex_mem_valid;
  logic          ex_mem_memory_read;
  logic          ex_mem_memory_write;
  logic [31:0]   ex_mem_memory_address;
  logic [31:0]   ex_mem_memory_write_data;
  logic          mem_stall;
  logic          dm_memory_read;
  logic          dm_memory_write;
  logic [AW-1:0] dm_memory_address;
  logic [31:0]   dm_memory_write_data;
  logic [31:0]   dm_read_data;
  logic          mem_wb_valid;
  logic [31:0]   mem_wb_read_data;
  logic          mem_wb_addr_error;

  mem_access_ctrl #(
    .MEM_DEPTH   (MEM_DEPTH),
    .WAIT_CYCLES (W)
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
    .ex_mem_valid             (ex_mem_valid),
    .ex_mem_memory_read       (ex_mem_memory_read),
    .ex_mem_memory_write      (ex_mem_memory_write),
    .ex_mem_memory_address    (ex_mem_memory_address),
    .ex_mem_memory_write_data (ex_mem_memory_write_data),
    .mem_stall                (mem_stall),
    .dm_memory_read           (dm_memory_read),
    .dm_memory_write          (dm_memory_write),
    .dm_memory_address        (dm_memory_address),
    .dm_memory_write_data     (dm_memory_write_data),
    .dm_read_data             (dm_read_data),
    .mem_wb_valid             (mem_wb_valid),
    .mem_wb_read_data         (mem_wb_read_data),
    .mem_wb_addr_error        (mem_wb_addr_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference memory (updated at request level) and the memory the DUT actually talks to.
  logic [31:0] ref_mem [MEM_DEPTH];
  logic [31:0] dmem    [MEM_DEPTH];

  assign dm_read_data = dmem[dm_memory_address];

  // Physical memory: latches on the rising edge of the write strobe.
  initial begin
    #1;
    for (int i = 0; i < MEM_DEPTH; i++) dmem[i] = ref_mem[i];
    forever begin
      @(posedge dm_memory_write);
      dmem[dm_memory_address] = dm_memory_write_data;
    end
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        err;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] last_data;
  logic        last_err;

  // Result monitor: every beat must match the oldest outstanding expectation, in its cycle.
  always @(negedge clk) begin
    if (rst) begin
      last_data = 32'd0;
      last_err  = 1'b0;
    end else begin
      check_val("rd_wr_excl", 32'(dm_memory_read & dm_memory_write), 32'd0);
      if (mem_wb_valid) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_beat", 32'(mem_wb_valid), 32'd0);
        end else begin
          beat_t b;
          b = exp_q.pop_front();
          check_val("beat_cycle", 32'(cyc), 32'(b.cyc));
          check_val("beat_data", mem_wb_read_data, b.data);
          check_val("beat_err", 32'(mem_wb_addr_error), 32'(b.err));
        end
        last_data = mem_wb_read_data;
        last_err  = mem_wb_addr_error;
      end else begin
        check_val("hold_data", mem_wb_read_data, last_data);
        check_val("hold_err", 32'(mem_wb_addr_error), 32'(last_err));
      end
    end
  end

  function automatic bit is_legal(input logic rd, input logic wr, input logic [31:0] addr);
    return (rd != wr) && (addr % 4 == 0) && ((addr >> 2) < MEM_DEPTH);
  endfunction

  task automatic present(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wdat);
    ex_mem_valid             = 1'b1;
    ex_mem_memory_read       = rd;
    ex_mem_memory_write      = wr;
    ex_mem_memory_address    = addr;
    ex_mem_memory_write_data = wdat;
  endtask

  task automatic idle_cycle();
    ex_mem_valid             = 1'b0;
    ex_mem_memory_read       = 1'($urandom);
    ex_mem_memory_write      = 1'($urandom);
    ex_mem_memory_address    = $urandom;
    ex_mem_memory_write_data = $urandom;
    @(posedge clk); #1;
  endtask

  task automatic check_reset_state();
    check_val("rst_stall", 32'(mem_stall), 32'd0);
    check_val("rst_rd", 32'(dm_memory_read), 32'd0);
    check_val("rst_wr", 32'(dm_memory_write), 32'd0);
    check_val("rst_addr", 32'(dm_memory_address), 32'd0);
    check_val("rst_wdata", dm_memory_write_data, 32'd0);
    check_val("rst_wb_valid", 32'(mem_wb_valid), 32'd0);
    check_val("rst_wb_data", mem_wb_read_data, 32'd0);
    check_val("rst_wb_err", 32'(mem_wb_addr_error), 32'd0);
  endtask

  // Issue one request (called at posedge+1), follow it until stall drops, check strobes per cycle.
  task automatic run_req(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wdat);
    bit    legal;
    bit    is_ld;
    bit    is_st;
    int    idx;
    int    lat;
    int    stall_len;
    int    k;
    beat_t b;
    legal     = is_legal(rd, wr, addr);
    is_ld     = legal && rd;
    is_st     = legal && wr;
    idx       = int'(addr >> 2);
    lat       = is_ld ? W + 2 : (is_st ? 4 : 1);
    stall_len = is_ld ? W + 1 : (is_st ? 3 : 0);
    present(rd, wr, addr, wdat);
    b.cyc  = cyc + lat;
    b.err  = (rd || wr) && !legal;
    b.data = is_ld ? ref_mem[idx] : 32'd0;
    exp_q.push_back(b);
    if (is_st) ref_mem[idx] = wdat;
    k = 0;
    forever begin
      @(negedge clk);
      check_val("rd_strobe", 32'(dm_memory_read), 32'(is_ld && k >= 1));
      check_val("wr_strobe", 32'(dm_memory_write), 32'(is_st && k == 2));
      check_val("dm_addr", 32'(dm_memory_address), (legal && k >= 1) ? 32'(idx) : 32'd0);
      if (is_st && k >= 1) check_val("dm_wdata", dm_memory_write_data, wdat);
      if (!mem_stall) break;
      k++;
      if (k > lat + 4) break;
    end
    check_val("stall_len", 32'(k), 32'(stall_len));
    @(posedge clk); #1;
    ex_mem_valid = 1'b0;
  endtask

  // Issue a legal request, then assert reset for two edges starting in cycle n (n >= 1).
  task automatic abort_req(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wdat,
                           input int n);
    int idx;
    idx = int'(addr >> 2);
    present(rd, wr, addr, wdat);
    repeat (n) begin
      @(posedge clk); #1;
    end
    ex_mem_valid = 1'b0;
    rst          = 1'b1;
    // A store whose strobe has already risen has reached memory.
    if (wr && n >= 2) ref_mem[idx] = wdat;
    @(negedge clk);
    check_val("abort_strobes", {30'd0, dm_memory_read, dm_memory_write},
              rd ? 32'd2 : ((n == 2) ? 32'd1 : 32'd0));
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_state();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        r_rd;
    logic        r_wr;
    logic [31:0] a;
    logic [31:0] d;
    int          sel;

    rst                      = 1'b1;
    ex_mem_valid             = 1'b0;
    ex_mem_memory_read       = 1'b0;
    ex_mem_memory_write      = 1'b0;
    ex_mem_memory_address    = 32'd0;
    ex_mem_memory_write_data = 32'd0;
    for (int i = 0; i < MEM_DEPTH; i++) ref_mem[i] = $urandom;
    ref_mem[4] = 32'h0000_000C;

    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_state();
    @(posedge clk); #1;
    rst = 1'b0;

    // Load of word 4 with the default wait states.
    run_req(1'b1, 1'b0, 32'h10, 32'd0);
    // Store then load back.
    run_req(1'b0, 1'b1, 32'h20, 32'hDEAD_BEEF);
    run_req(1'b1, 1'b0, 32'h20, 32'd0);
    // Misaligned, out of range, read+write together.
    run_req(1'b1, 1'b0, 32'h13, 32'd0);
    run_req(1'b1, 1'b0, 32'h200, 32'd0);
    run_req(1'b1, 1'b1, 32'h20, 32'h1234_5678);
    idle_cycle();
    // Back-to-back store, load, non-memory.
    run_req(1'b0, 1'b1, 32'h20, 32'hCAFE_F00D);
    run_req(1'b1, 1'b0, 32'h20, 32'd0);
    run_req(1'b0, 1'b0, 32'h44, 32'd0);
    idle_cycle();
    // Reset in the middle of a load, then reset during write setup.
    abort_req(1'b1, 1'b0, 32'h10, 32'd0, 2);
    abort_req(1'b0, 1'b1, 32'h24, 32'hBAD0_BAD0, 1);
    run_req(1'b1, 1'b0, 32'h24, 32'd0);

    for (int it = 0; it < 250; it++) begin
      sel  = int'($urandom_range(0, 9));
      r_rd = (sel <= 3) || (sel == 9);
      r_wr = (sel >= 4 && sel <= 7) || (sel == 9);
      case ($urandom_range(0, 7))
        0:       a = $urandom;
        1:       a = {23'd0, 7'($urandom_range(0, 127)), 2'($urandom_range(1, 3))};
        default: a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      endcase
      d = $urandom;
      if ($urandom_range(0, 19) == 0 && is_legal(r_rd, r_wr, a))
        abort_req(r_rd, r_wr, a, d, r_rd ? int'($urandom_range(1, W + 1)) : int'($urandom_range(1, 3)));
      else
        run_req(r_rd, r_wr, a, d);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) idle_cycle();
      end
    end

    repeat (6) idle_cycle();
    check_val("beats_left", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < MEM_DEPTH; i++) check_val("mem_word", dmem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
